// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the data-memory access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_ctrl_pkg;

  // Access sequencer states: waiting for an instruction, access in flight, completion cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default word-address width presented to data memory
  localparam int MEM_ADDR_W_DEF = 16;

  // Default BUSY-cycle limit before an unanswered access is abandoned
  localparam int MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_timeout_cnt.sv
// BUSY-cycle counter: flags the cycle in which an access has waited LIMIT cycles.
// Latency: expired is combinational from the registered count (asserted in the LIMIT-th enabled cycle).
// Backpressure: none; counting saturates at the limit until cleared.
module mem_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The count equals the number of enabled cycles already completed, so the
  // LIMIT-th enabled cycle is the one that sees LAST.
  assign expired = en && (cnt_q == LAST);

  // Clear takes priority so the first enabled cycle after a clear starts at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one load/store from the EXE/MEM register into a registered data-memory request; optional timeout under MEM_ACCESS_TIMEOUT_EN.
// Latency: request registered one cycle after the instruction is seen; result in the DONE cycle right after mem_ack (min 3 cycles per access).
// Backpressure: freeze holds every pipeline stage while the access is pending; mem_ack is the only completion handshake.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       ST_val,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              freeze,
  output logic [31:0]       read_data,
  output logic              err
);

  state_t state_q, state_d;

  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              err_q,       err_d;

  logic start;
  logic timeout_hit;

  // Byte offset and bits above the word-address window never reach memory
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ALU_result[31:ADDR_W+2], ALU_result[1:0]};

  assign start = MEM_R_EN | MEM_W_EN;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic cnt_expired;

  // Count is held at zero outside BUSY so every access starts a fresh window
  mem_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != BUSY),
    .en      (state_q == BUSY),
    .expired (cnt_expired)
  );

  // An ack arriving on the limit cycle still wins over the timeout
  assign timeout_hit = cnt_expired & ~mem_ack;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  // State register; reset abandons any in-flight access without reissue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> BUSY on any memory op, BUSY -> DONE on ack/timeout, DONE always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (mem_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: latch request in IDLE, hold through BUSY, retire on completion
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    read_data_d = read_data_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mem_req_d   = 1'b1;
          // A simultaneous load+store is issued as a store only
          mem_we_d    = MEM_W_EN;
          mem_addr_d  = ALU_result[ADDR_W+1:2];
          mem_wdata_d = ST_val;
        end
      end
      BUSY: begin
        if (mem_ack || timeout_hit) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          // mem_we_q still identifies the access type during BUSY
          if (!mem_we_q) begin
            read_data_d = mem_ack ? mem_rdata : '0;
          end
          err_d = timeout_hit;
        end
      end
      default: ;
    endcase
  end

  // Registered memory interface, load result and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      read_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      read_data_q <= read_data_d;
      err_q       <= err_d;
    end
  end

  // Stall is combinational so the instruction is held from the very cycle it appears
  assign freeze = ~rst & (((state_q == IDLE) & start) | (state_q == BUSY));

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign read_data = read_data_q;
  assign err       = err_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, 16, word-address width driven to data memory.
REQ-002 Parameter TIMEOUT_CYCLES, 255, BUSY-cycle limit (used only with MEM_ACCESS_TIMEOUT_EN).
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 MEM_R_EN  in  1  load request from EXE/MEM stage register.
REQ-006 MEM_W_EN  in  1  store request from EXE/MEM stage register.
REQ-007 ALU_result  in  32  byte address from EXE/MEM stage register.
REQ-008 ST_val  in  32  store data from EXE/MEM stage register.
REQ-009 mem_req  out  1  registered access request to data memory.
REQ-010 mem_we  out  1  registered write strobe; valid while mem_req=1.
REQ-011 mem_addr  out  ADDR_W  registered word address = ALU_result[ADDR_W+1:2].
REQ-012 mem_wdata  out  32  registered store data.
REQ-013 mem_ack  in  1  memory completion, sampled only while mem_req=1.
REQ-014 mem_rdata  in  32  load data, valid with mem_ack.
REQ-015 freeze  out  1  combinational hold for all pipeline stage registers.
REQ-016 read_data  out  32  registered load result to MEM/WB register.
REQ-017 err  out  1  one-cycle timeout pulse.

Function
REQ-018 FSM states: IDLE, BUSY, DONE.
REQ-019 IDLE, MEM_R_EN|MEM_W_EN=1 -> BUSY next edge; mem_req<=1, mem_we<=MEM_W_EN, mem_addr/mem_wdata latched from inputs.
REQ-020 MEM_R_EN=MEM_W_EN=1 simultaneously: store wins, no load performed, read_data unchanged.
REQ-021 BUSY, mem_ack=1 -> DONE; mem_req<=0, mem_we<=0; on load read_data<=mem_rdata, on store read_data unchanged.
REQ-022 BUSY, mem_ack=0 -> stay BUSY, outputs to memory held stable.
REQ-023 DONE -> IDLE unconditionally next edge; no new access starts from DONE.
REQ-024 freeze = (IDLE & (MEM_R_EN|MEM_W_EN)) | BUSY; freeze=0 in DONE.
REQ-025 Latency: ack in first BUSY cycle -> freeze high 2 cycles, instruction occupies stage 3 cycles; each extra wait cycle adds 1.
REQ-026 Back-to-back accesses: next instruction seen in IDLE cycle after DONE, restarts sequence with no bubble beyond DONE.
REQ-027 mem_ack outside BUSY ignored.
REQ-028 Non-memory instruction in IDLE: freeze=0, no state change.

Reset
REQ-029 rst asserted, any state incl. mid-access: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, read_data=0, err=0, timeout count=0.
REQ-030 freeze forced 0 while rst=1.
REQ-031 Access aborted by reset is not reissued; first edge after release evaluates inputs as IDLE.

Configuration
REQ-032 Macro MEM_ACCESS_TIMEOUT_EN defined: BUSY-cycle counter; count reaching TIMEOUT_CYCLES without ack -> DONE, mem_req<=0, read_data<=0 on load, err=1 for one cycle (DONE cycle).
REQ-033 Counter clears on entry to BUSY; ack on the limit cycle counts as success, err=0.
REQ-034 Macro undefined: no counter, BUSY waits indefinitely, err tied 0.

Structure
REQ-035 Package mem_ctrl_pkg holds state enum (IDLE/BUSY/DONE) and ADDR_W default constant.
REQ-036 Timeout counter is a sub-module mem_timeout_cnt, instantiated only under MEM_ACCESS_TIMEOUT_EN.

Verification
REQ-037 Load ALU_result=0x0000_0408, ack after 3 BUSY cycles, mem_rdata=0xDEAD_BEEF -> mem_addr=0x0102, freeze high 4 cycles, read_data=0xDEADBEEF in DONE.
REQ-038 Store ST_val=0x1234_5678, immediate ack -> mem_we=1 one cycle, mem_wdata=0x12345678, freeze high 2 cycles, read_data unchanged.
REQ-039 Load then store back-to-back -> two full IDLE-BUSY-DONE sequences, freeze low only in each DONE cycle.
REQ-040 rst pulse in 2nd BUSY cycle -> mem_req=0 and freeze=0 immediately, all outputs 0, no access reissued.
REQ-041 MEM_R_EN=MEM_W_EN=1 -> mem_we=1, read_data unchanged.
REQ-042 With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> DONE after 4 BUSY cycles, err pulse 1 cycle, read_data=0.
